game_io_bridge: RTL and testbench

Parametrised frame-synchronous bridge between the game CPU and the VGA display path. Debounces the jump button, double-buffers N sprite coordinate pairs so the display only sees a complete, CPU-committed set at frame boundaries, and provides a level-held `screen_ready` handshake that the CPU clears by committing. It generalises the fixed two-sprite, raw-wire coupling of the current game top.

---
 rtl/game_io_bridge.sv | 118 +++++++++++
 tb/tb_game_io_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_io_bridge.sv
// Frame-synchronous CPU/display bridge: button debouncer, double-buffered sprite coordinates,
// screen_ready handshake and frame counters. Optional GAME_IO_BRIDGE_MISS_CNT_EN enables missed_frames.
module game_io_bridge #(
  parameter int unsigned NUM_SPRITES     = 2,
  parameter int unsigned COORD_W         = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               button_raw,
  input  logic [2*NUM_SPRITES*COORD_W-1:0]   cpu_coords,
  input  logic                               cpu_commit,
  input  logic                               frame_end,
  output logic                               button_level,
  output logic                               button_rise,
  output logic                               screen_ready,
  output logic [2*NUM_SPRITES*COORD_W-1:0]   disp_coords,
  output logic [15:0]                        frame_count,
  output logic [7:0]                         missed_frames
);

  localparam int unsigned BUS_W = 2 * NUM_SPRITES * COORD_W;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_WAIT    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic             sync_ff;
  logic             btn_sync;
  logic [CNT_W-1:0] db_cnt;
  logic             btn_diff_c;
  logic             btn_toggle_c;

  state_t           state_q;
  state_t           state_d;
  logic             load_disp_c;
  logic [BUS_W-1:0] staging;

  assign btn_diff_c   = (btn_sync != button_level);
  assign btn_toggle_c = btn_diff_c && (db_cnt == CNT_LAST);

  // Synchroniser plus stability counter; the level only flips after a full run of differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff      <= 1'b0;
      btn_sync     <= 1'b0;
      db_cnt       <= '0;
      button_level <= 1'b0;
      button_rise  <= 1'b0;
    end else begin
      sync_ff     <= button_raw;
      btn_sync    <= sync_ff;
      button_rise <= btn_toggle_c && !button_level;
      if (btn_toggle_c) begin
        button_level <= ~button_level;
        db_cnt       <= '0;
      end else if (btn_diff_c) begin
        db_cnt <= db_cnt + CNT_W'(1);
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_WAIT;
    else        state_q <= state_d;
  end

  // frame_end acts on the pre-cycle state; a same-cycle commit then leaves the FSM in PENDING.
  always_comb begin
    state_d     = state_q;
    load_disp_c = 1'b0;
    if (frame_end && (state_q == ST_PENDING)) begin
      load_disp_c = 1'b1;
      state_d     = ST_WAIT;
    end
    if (cpu_commit) begin
      state_d = ST_PENDING;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      staging      <= '0;
      disp_coords  <= '0;
      screen_ready <= 1'b0;
      frame_count  <= '0;
    end else begin
      if (cpu_commit) staging <= cpu_coords;
      if (load_disp_c) disp_coords <= staging;
      if (frame_end) frame_count <= frame_count + 16'd1;
      if (cpu_commit)     screen_ready <= 1'b0;
      else if (frame_end) screen_ready <= 1'b1;
    end
  end

`ifdef GAME_IO_BRIDGE_MISS_CNT_EN
  logic [7:0] miss_q;

  // Counts frame boundaries that found no committed coordinate set; sticks at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_q <= '0;
    end else if (frame_end && (state_q == ST_WAIT) && (miss_q != 8'hFF)) begin
      miss_q <= miss_q + 8'd1;
    end
  end

  assign missed_frames = miss_q;
`else
  assign missed_frames = 8'd0;
`endif

endmodule

// File: tb/tb_game_io_bridge.sv
// Scoreboard bench for game_io_bridge: stimulus pushes model predictions, a monitor pops and compares.
module tb_game_io_bridge;

  localparam int unsigned NS = 2;
  localparam int unsigned CW = 32;
  localparam int unsigned DB = 4;
  localparam int unsigned BW = 2 * NS * CW;

  logic          clk;
  logic          reset;
  logic          button_raw;
  logic [BW-1:0] cpu_coords;
  logic          cpu_commit;
  logic          frame_end;
  logic          button_level;
  logic          button_rise;
  logic          screen_ready;
  logic [BW-1:0] disp_coords;
  logic [15:0]   frame_count;
  logic [7:0]    missed_frames;

  game_io_bridge #(
    .NUM_SPRITES(NS),
    .COORD_W(CW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .cpu_coords(cpu_coords),
    .cpu_commit(cpu_commit),
    .frame_end(frame_end),
    .button_level(button_level),
    .button_rise(button_rise),
    .screen_ready(screen_ready),
    .disp_coords(disp_coords),
    .frame_count(frame_count),
    .missed_frames(missed_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          level;
    logic          rise;
    logic          ready;
    logic [BW-1:0] disp;
    logic [15:0]   fc;
    logic [7:0]    missed;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  logic          m_raw_d1, m_raw_d2;
  logic          m_level, m_rise, m_ready, m_pending;
  int            m_run;
  logic [BW-1:0] m_staging, m_disp;
  int            m_fc;
  int            m_missed;

  function automatic logic [BW-1:0] pack4(input int x0, input int y0, input int x1, input int y1);
    return {CW'(y1), CW'(x1), CW'(y0), CW'(x0)};
  endfunction

  function automatic logic [BW-1:0] fill(input int v);
    return {CW'(v), CW'(v), CW'(v), CW'(v)};
  endfunction

  function automatic int miss_expect(input int n);
`ifdef GAME_IO_BRIDGE_MISS_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_raw_d1 = 1'b0; m_raw_d2 = 1'b0;
    m_level = 1'b0; m_rise = 1'b0; m_ready = 1'b0; m_pending = 1'b0;
    m_run = 0; m_staging = '0; m_disp = '0; m_fc = 0; m_missed = 0;
  endtask

  // Drive one cycle of inputs and predict the outputs after the next rising edge.
  task automatic step(input logic raw, input logic [BW-1:0] coords, input logic commit, input logic fe);
    exp_t e;
    @(negedge clk);
    button_raw = raw;
    cpu_coords = coords;
    cpu_commit = commit;
    frame_end  = fe;
    // Debounce: level flips once the synchronised input has disagreed for DB consecutive cycles.
    m_rise = 1'b0;
    if (m_raw_d2 != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = ~m_level;
        m_rise  = m_level;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_raw_d2 = m_raw_d1;
    m_raw_d1 = raw;
    // Frame boundary sees the old commit; a new commit is captured afterwards.
    if (fe) begin
      m_fc = (m_fc + 1) % 65536;
      if (m_pending) begin
        m_disp    = m_staging;
        m_pending = 1'b0;
      end else if (m_missed < 255) begin
        m_missed++;
      end
      m_ready = 1'b1;
    end
    if (commit) begin
      m_staging = coords;
      m_pending = 1'b1;
      m_ready   = 1'b0;
    end
    e.level  = m_level;
    e.rise   = m_rise;
    e.ready  = m_ready;
    e.disp   = m_disp;
    e.fc     = 16'(m_fc);
    e.missed = 8'(miss_expect(m_missed));
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    button_raw = 1'b0; cpu_commit = 1'b0; frame_end = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_level",  BW'(button_level),  '0);
    chk("rst_rise",   BW'(button_rise),   '0);
    chk("rst_ready",  BW'(screen_ready),  '0);
    chk("rst_disp",   disp_coords,        '0);
    chk("rst_fc",     BW'(frame_count),   '0);
    chk("rst_missed", BW'(missed_frames), '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compare every registered output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("level",  BW'(button_level),  BW'(e.level));
        chk("rise",   BW'(button_rise),   BW'(e.rise));
        chk("ready",  BW'(screen_ready),  BW'(e.ready));
        chk("disp",   disp_coords,        e.disp);
        chk("fcount", BW'(frame_count),   BW'(e.fc));
        chk("missed", BW'(missed_frames), BW'(e.missed));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [BW-1:0] cur;
  logic          r;

  initial begin
    reset = 1'b1; button_raw = 1'b0; cpu_coords = '0; cpu_commit = 1'b0; frame_end = 1'b0;
    cur = '0;
    model_reset();
    do_reset();

    // Short glitch then a long press and release
    repeat (3) step(1'b1, cur, 1'b0, 1'b0);
    repeat (8) step(1'b0, cur, 1'b0, 1'b0);
    repeat (10) step(1'b1, cur, 1'b0, 1'b0);
    repeat (10) step(1'b0, cur, 1'b0, 1'b0);

    // Double buffer: later cpu_coords changes must not leak to the display
    step(1'b0, pack4(100, 200, 640, 200), 1'b1, 1'b0);
    step(1'b0, fill(7), 1'b0, 1'b0);
    step(1'b0, fill(7), 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("dbuf_disp",  disp_coords, pack4(100, 200, 640, 200));
    chk("dbuf_ready", BW'(screen_ready), BW'(1));

    // Missed frames then saturation
    repeat (3) begin
      step(1'b0, fill(7), 1'b0, 1'b1);
      step(1'b0, fill(7), 1'b0, 1'b0);
    end
    @(posedge clk); #2;
    chk("miss3_missed", BW'(missed_frames), BW'(miss_expect(3)));
    chk("miss3_disp",   disp_coords, pack4(100, 200, 640, 200));
    chk("miss3_fcount", BW'(frame_count), BW'(4));
    repeat (300) step(1'b0, fill(7), 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("miss_sat", BW'(missed_frames), BW'(miss_expect(255)));

    // Simultaneous frame_end and commit while waiting
    step(1'b0, fill(5), 1'b1, 1'b1);
    step(1'b0, fill(9), 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("simul_disp",  disp_coords, pack4(100, 200, 640, 200));
    chk("simul_ready", BW'(screen_ready), BW'(0));
    step(1'b0, fill(9), 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("simul_next_disp", disp_coords, fill(5));

    // Reset mid-debounce with a pending commit
    step(1'b0, fill(3), 1'b1, 1'b0);
    step(1'b1, fill(3), 1'b0, 1'b0);
    step(1'b1, fill(3), 1'b0, 1'b0);
    step(1'b1, fill(3), 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("post_rst_missed", BW'(missed_frames), BW'(miss_expect(1)));
    chk("post_rst_ready",  BW'(screen_ready), BW'(1));
    chk("post_rst_disp",   disp_coords, '0);

    // Randomised traffic with a sticky button
    r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r = ~r;
      cur = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(r, cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    // frame_count wrap
    do_reset();
    repeat (65536) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("wrap_fcount", BW'(frame_count), '0);

    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending predictions", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
